ddr_rd_unpack: RTL

- Downstream stage of the DDR controller read path.
- Accepts 256-bit read beats (data plus enable) and buffers them in a small FIFO.
- Drives the controller's downstream-full throttle input.
- Serialises each beat into 32-bit words on a valid/ready stream for the acquisition/uplink logic.
- Keeps a sticky overflow flag and a transferred-word counter for status registers.

---
 rtl/ddr_rd_pkg.sv | 28 ++
 rtl/ddr_rd_fifo_fwft.sv | 83 ++++++++
 rtl/ddr_rd_unpack.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ddr_rd_pkg.sv
// Shared constants and parameter checks for the DDR read-path unpacker.
// Sizes the default 256-bit beat to 32-bit word conversion.
package ddr_rd_pkg;

  localparam int DDR_BEAT_W = 256;
  localparam int RD_WORD_W  = 32;
  localparam int RD_RATIO   = DDR_BEAT_W / RD_WORD_W;
  localparam int RD_IDX_W   = $clog2(RD_RATIO);

  function automatic bit ddr_rd_is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Legal set: whole power-of-two word ratio of at least two, power-of-two
  // FIFO of at least four entries, and a throttle margin below the depth.
  function automatic bit ddr_rd_cfg_ok(input int in_w, input int out_w,
                                       input int depth, input int margin);
    bit ok;
    ok = (out_w > 0) && (in_w > out_w) && ((in_w % out_w) == 0);
    if (ok) begin
      ok = ddr_rd_is_pow2(in_w / out_w);
    end
    ok = ok && ddr_rd_is_pow2(depth) && (depth >= 4);
    ok = ok && (margin >= 0) && (margin < depth);
    return ok;
  endfunction

endpackage

// File: rtl/ddr_rd_fifo_fwft.sv
// First-word-fall-through FIFO: the head entry is read straight from the
// storage array, so a pop consumes the word already visible on o_head.
module ddr_rd_fifo_fwft
  import ddr_rd_pkg::*;
#(
  parameter int WIDTH = DDR_BEAT_W,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  if (!ddr_rd_is_pow2(DEPTH) || DEPTH < 4) begin : g_depth_err
    $error("ddr_rd_fifo_fwft: DEPTH must be a power of two and at least 4");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok;
  logic             pop_ok;

  assign o_full  = (level_q == LVL_W'(DEPTH));
  assign o_empty = (level_q == '0);
  assign o_level = level_q;
  assign o_head  = mem[rd_ptr_q];

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    pop_ok   = i_pop & ~o_empty;
    // A full FIFO still takes a push when the same cycle frees an entry.
    push_ok  = i_push & (~o_full | pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers and level already mark
  // every entry invalid, and a reset would stop it mapping onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= i_push_data;
    end
  end

endmodule

// File: rtl/ddr_rd_unpack.sv
// DDR read-path unpacker: buffers 256-bit read beats, throttles the controller
// and serialises each beat into 32-bit words on a valid/ready stream.
module ddr_rd_unpack
  import ddr_rd_pkg::*;
#(
  parameter int IN_WIDTH     = DDR_BEAT_W,
  parameter int OUT_WIDTH    = RD_WORD_W,
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_MARGIN = 8,
  parameter bit LSB_FIRST    = 1'b1
) (
  input  logic                          ddr_ui_clk,
  input  logic                          ddr_log_rst_n,
  input  logic [IN_WIDTH-1:0]           i_ddr_rd_data,
  input  logic                          i_ddr_rd_data_en,
  output logic                          o_dn_full,
  output logic [OUT_WIDTH-1:0]          o_data,
  output logic                          o_data_valid,
  input  logic                          i_data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_ovf_err,
  input  logic                          i_stat_clr,
  output logic [31:0]                   o_word_cnt
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(RATIO - 1);
  localparam logic [LVL_W-1:0] AFULL_LVL = LVL_W'(FIFO_DEPTH - AFULL_MARGIN);

  if (!ddr_rd_cfg_ok(IN_WIDTH, OUT_WIDTH, FIFO_DEPTH, AFULL_MARGIN)) begin : g_cfg_err
    $error("ddr_rd_unpack: illegal width/depth/margin parameter set");
  end

  logic [IN_WIDTH-1:0]  fifo_head;
  logic [LVL_W-1:0]     fifo_level;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;

  logic                 hold_vld_q, hold_vld_d;
  logic [IN_WIDTH-1:0]  hold_data_q, hold_data_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 ovf_q, ovf_d;
  logic [31:0]          word_cnt_q, word_cnt_d;

  logic                 xfer;
  logic                 load;
  logic                 ovf_evt;
  logic [IDX_W-1:0]     slice_sel;

  ddr_rd_fifo_fwft #(
    .WIDTH (IN_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (ddr_ui_clk),
    .rst_n       (ddr_log_rst_n),
    .i_push      (i_ddr_rd_data_en),
    .i_push_data (i_ddr_rd_data),
    .i_pop       (fifo_pop),
    .o_head      (fifo_head),
    .o_level     (fifo_level),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty)
  );

  always_comb begin
    xfer = hold_vld_q & i_data_ready;
    // Reload on the final slice as well as when empty: this keeps consecutive
    // beats streaming at one word per clock with no bubble between them.
    load     = ~hold_vld_q | (xfer & (idx_q == LAST_IDX));
    fifo_pop = load & ~fifo_empty;
    ovf_evt  = i_ddr_rd_data_en & fifo_full & ~fifo_pop;

    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    idx_d       = idx_q;
    if (load) begin
      hold_vld_d = ~fifo_empty;
      idx_d      = '0;
      if (!fifo_empty) begin
        hold_data_d = fifo_head;
      end
    end else if (xfer) begin
      idx_d = idx_q + IDX_W'(1);
    end

    ovf_d = ovf_q;
    if (ovf_evt) begin
      ovf_d = 1'b1;
    end else if (i_stat_clr) begin
      ovf_d = 1'b0;
    end

    word_cnt_d = word_cnt_q;
    if (i_stat_clr) begin
      word_cnt_d = '0;
    end else if (xfer) begin
      word_cnt_d = word_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge ddr_ui_clk or negedge ddr_log_rst_n) begin
    if (!ddr_log_rst_n) begin
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      idx_q       <= '0;
      ovf_q       <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
      idx_q       <= idx_d;
      ovf_q       <= ovf_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  always_comb begin
    slice_sel = LSB_FIRST ? idx_q : (LAST_IDX - idx_q);
    o_data    = hold_data_q[slice_sel*OUT_WIDTH +: OUT_WIDTH];
  end

  // Throttle is decoded from the level register only, so it cannot glitch.
  assign o_dn_full    = (fifo_level >= AFULL_LVL);
  assign o_data_valid = hold_vld_q;
  assign o_fifo_level = fifo_level;
  assign o_ovf_err    = ovf_q;
  assign o_word_cnt   = word_cnt_q;

endmodule
